// File: rtl/mux_sel_pipe.sv
// ----------------------------------------------------------------------------
// mux_sel_pipe
//
// Purpose:
//   N-way, WIDTH-bit registered selector with a valid/ready handshake on both
//   sides and a two-entry skid buffer. Each upstream transfer picks one of
//   NUM_IN candidate words by 'select' and queues it. The queue has two slots:
//   the main register, which drives data_out, and a skid register.
//
//   An out-of-range select queues DEFAULT_VAL with the sel_err sideband set.
//   in_ready is decoded purely from the state register. This means there is
//   no combinational path from out_ready to in_ready.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous, active-high reset
//   data_in    in   NUM_IN*WIDTH  packed candidates, word i at [i*WIDTH +: WIDTH]
//   select     in   SEL_W         word index, sampled with the upstream transfer
//   in_valid   in   1             upstream offers a word/select pair
//   in_ready   out  1             block can accept this cycle
//   data_out   out  WIDTH         registered selected word
//   out_valid  out  1             data_out/sel_err hold a valid entry
//   out_ready  in   1             downstream accepts this cycle
//   sel_err    out  1             current output came from an out-of-range select
// ----------------------------------------------------------------------------
module mux_sel_pipe #(
    parameter int                WIDTH       = 8,
    parameter int                NUM_IN      = 2,
    parameter int                SEL_W       = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        select,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // Occupancy of the two-slot buffer. The main register is always the older
    // entry when both slots are full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [WIDTH-1:0]   r_mainData;
    logic               r_mainErr;
    logic [WIDTH-1:0]   r_skidData;
    logic               r_skidErr;

    logic [WIDTH-1:0]   w_entryData;
    logic               w_entryErr;

    logic               w_inFire;
    logic               w_outFire;
    logic               w_loadMainEntry;
    logic               w_loadMainSkid;
    logic               w_loadSkid;

    // Both handshake outputs are decoded from the state register alone.
    // As a result, downstream back-pressure never ripples combinationally
    // upstream.
    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign data_out  = r_mainData;
    assign sel_err   = r_mainErr;

    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;

    // Build the candidate entry as a one-hot compare mux rather than a
    // variable part-select. An unselected input word, even one that is X,
    // can then never leak into the result. Any select code with no matching
    // input falls through to the default. This covers the unused codes when
    // NUM_IN is not a power of two.
    always_comb begin
        w_entryData = DEFAULT_VAL;
        w_entryErr  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (select == SEL_W'(i)) begin
                w_entryData = data_in[i*WIDTH +: WIDTH];
                w_entryErr  = 1'b0;
            end
        end
    end

    // Next-state and register-load decode.
    // When full, the upstream side is blocked by in_ready. Therefore TWO
    // only has to handle a drain, which moves the skid entry into main.
    always_comb begin
        w_nextState     = r_state;
        w_loadMainEntry = 1'b0;
        w_loadMainSkid  = 1'b0;
        w_loadSkid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_inFire) begin
                    w_nextState     = ONE;
                    w_loadMainEntry = 1'b1;
                end
            end
            ONE: begin
                if (w_inFire && w_outFire) begin
                    w_nextState     = ONE;
                    w_loadMainEntry = 1'b1;
                end else if (w_inFire) begin
                    w_nextState = TWO;
                    w_loadSkid  = 1'b1;
                end else if (w_outFire) begin
                    w_nextState = EMPTY;
                end
            end
            TWO: begin
                if (w_outFire) begin
                    w_nextState    = ONE;
                    w_loadMainSkid = 1'b1;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
    end

    // State register. An asynchronous reset discards any held words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Main register. It only changes on a load. Its contents therefore stay
    // frozen while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mainData <= '0;
            r_mainErr  <= 1'b0;
        end else if (w_loadMainEntry) begin
            r_mainData <= w_entryData;
            r_mainErr  <= w_entryErr;
        end else if (w_loadMainSkid) begin
            r_mainData <= r_skidData;
            r_mainErr  <= r_skidErr;
        end
    end

    // Skid register. It only captures when a new word arrives while main is
    // occupied and not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skidData <= '0;
            r_skidErr  <= 1'b0;
        end else if (w_loadSkid) begin
            r_skidData <= w_entryData;
            r_skidErr  <= w_entryErr;
        end
    end

endmodule
